// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive and transmit paths.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_A   = 7;
  localparam int SAMPLE_B   = 8;
  localparam int SAMPLE_C   = 9;
  localparam int DATA_BITS  = 8;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t START = 3'd1;
  localparam state_t DATA  = 3'd2;
  localparam state_t STOP  = 3'd3;
  localparam state_t BREAK = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks; DIV=1 ticks every cycle.
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_div_check
    $error("baud_tick_gen: DIV must be >= 1");
  end

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 receiver: 16x oversampling with 3-sample majority voting, start/stop validation
// and a one-entry valid/ready holding register for the downstream consumer.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A    = SW'(SAMPLE_A);
  localparam logic [SW-1:0] S_B    = SW'(SAMPLE_B);
  localparam logic [SW-1:0] S_C    = SW'(SAMPLE_C);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic                 tick;
  logic                 rx_m;
  logic                 rx_s;
  state_t               state;
  logic [SW-1:0]        s;
  logic [2:0]           bit_idx;
  logic [2:0]           samp;
  logic [DATA_BITS-1:0] shift;
  logic                 deliver;
  logic                 bit_maj;
  logic                 stop_maj;
  logic                 sampling;

  baud_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RxD;
      rx_s <= rx_m;
    end
  end

  // The stop decision happens on the third sample tick itself, so it votes with the live rx_s.
  assign bit_maj  = majority3(samp[0], samp[1], samp[2]);
  assign stop_maj = majority3(samp[0], samp[1], rx_s);
  assign sampling = tick && (state == START || state == DATA || state == STOP);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s         <= '0;
      bit_idx   <= '0;
      samp      <= '0;
      shift     <= '0;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      deliver   <= 1'b0;
      frame_err <= 1'b0;

      if (sampling) begin
        s <= s + 1'b1;
        if (s == S_A) samp[0] <= rx_s;
        if (s == S_B) samp[1] <= rx_s;
        if (s == S_C) samp[2] <= rx_s;
      end

      case (state)
        IDLE: begin
          if (tick && !rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (tick && s == S_LAST) begin
            if (!bit_maj) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick && s == S_LAST) begin
            shift <= {bit_maj, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick && s == S_C) begin
            if (stop_maj) begin
              deliver <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A full register only takes the new byte when the consumer frees it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler at DIV=1 (one bit = 16 clocks): frame table, corner sequences,
// and a skewed random/sweep run scored against a byte-level model of the line.
module tb_uart_rx_sampler;

  logic       clk;
  logic       reset;
  logic       RxD;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int fe_count    = 0;
  int ov_count    = 0;
  int valid_count = 0;
  int both_count  = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic [8:0] exp_data;
    int         exp_bytes;
    int         exp_fe;
  } vec_t;

  vec_t vecs[8];

  uart_rx_sampler #(
    .CLK_FREQ(16_000_000),
    .BAUD    (1_000_000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RxD      (RxD),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe mid-cycle: an accepted byte is any cycle with rx_valid and rx_ready both high.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid) valid_count++;
      if (frame_err) fe_count++;
      if (overrun) ov_count++;
      if (frame_err && overrun) both_count++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic stepClk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame; period_x100 is the bit time in hundredths of a clock.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int period_x100);
    logic [9:0] frame;
    int t;
    int end_t;
    frame = {stop_bit, data, 1'b0};
    t = 0;
    for (int k = 0; k < 10; k++) begin
      end_t = ((k + 1) * period_x100 + 50) / 100;
      RxD = frame[k];
      while (t < end_t) begin
        stepClk(1);
        t++;
      end
    end
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] d;
    logic       good;
    int         b_got;
    int         b_fe;
    int         b_ov;
    int         b_val;
    int         p;
    int         exp_fe;
    int         holds[2];

    vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_data: 9'h0A5, exp_bytes: 1, exp_fe: 0};
    vecs[1] = '{data: 8'h00, stop_bit: 1'b1, exp_data: 9'h000, exp_bytes: 1, exp_fe: 0};
    vecs[2] = '{data: 8'hFF, stop_bit: 1'b1, exp_data: 9'h0FF, exp_bytes: 1, exp_fe: 0};
    vecs[3] = '{data: 8'h80, stop_bit: 1'b1, exp_data: 9'h080, exp_bytes: 1, exp_fe: 0};
    vecs[4] = '{data: 8'h01, stop_bit: 1'b1, exp_data: 9'h001, exp_bytes: 1, exp_fe: 0};
    vecs[5] = '{data: 8'h3C, stop_bit: 1'b0, exp_data: 9'h100, exp_bytes: 0, exp_fe: 1};
    vecs[6] = '{data: 8'h7E, stop_bit: 1'b0, exp_data: 9'h100, exp_bytes: 0, exp_fe: 1};
    vecs[7] = '{data: 8'h5A, stop_bit: 1'b1, exp_data: 9'h05A, exp_bytes: 1, exp_fe: 0};
    holds[0] = 40;
    holds[1] = 200;

    reset    = 1'b1;
    RxD      = 1'b1;
    rx_ready = 1'b0;
    stepClk(3);
    checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    checkOutput("reset_overrun", 32'(overrun), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    stepClk(20);

    $display("[TB] mid-frame reset");
    b_got = got_q.size(); b_fe = fe_count; b_ov = ov_count; b_val = valid_count;
    frame = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 16 * 4 + 5; c++) begin
      RxD = frame[c / 16];
      stepClk(1);
    end
    checkOutput("rstmid_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    RxD   = 1'b1;
    stepClk(1);
    reset = 1'b0;
    checkOutput("rstmid_busy_after", 32'(busy), 32'h0);
    stepClk(1);
    checkOutput("rstmid_busy_next", 32'(busy), 32'h0);
    stepClk(320);
    checkOutput("rstmid_valid_cycles", 32'(valid_count - b_val), 32'd0);
    checkOutput("rstmid_fe", 32'(fe_count - b_fe), 32'd0);
    checkOutput("rstmid_ov", 32'(ov_count - b_ov), 32'd0);

    $display("[TB] frame table");
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_got = got_q.size(); b_fe = fe_count; b_val = valid_count; b_ov = ov_count;
      applyStimulus(vecs[i].data, vecs[i].stop_bit, 1600);
      RxD = 1'b1;
      stepClk(48);
      checkOutput($sformatf("vec%0d_bytes", i), 32'(got_q.size() - b_got), 32'(vecs[i].exp_bytes));
      checkOutput($sformatf("vec%0d_data", i),
                  32'((got_q.size() > b_got) ? {1'b0, got_q[got_q.size() - 1]} : 9'h100),
                  32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_valid_cycles", i), 32'(valid_count - b_val), 32'(vecs[i].exp_bytes));
      checkOutput($sformatf("vec%0d_fe", i), 32'(fe_count - b_fe), 32'(vecs[i].exp_fe));
      checkOutput($sformatf("vec%0d_ov", i), 32'(ov_count - b_ov), 32'd0);
    end

    $display("[TB] glitch rejection");
    b_got = got_q.size(); b_fe = fe_count;
    RxD = 1'b0;
    stepClk(4);
    RxD = 1'b1;
    stepClk(1);
    checkOutput("glitch_busy_high", 32'(busy), 32'h1);
    stepClk(30);
    checkOutput("glitch_busy_low", 32'(busy), 32'h0);
    checkOutput("glitch_bytes", 32'(got_q.size() - b_got), 32'd0);
    checkOutput("glitch_fe", 32'(fe_count - b_fe), 32'd0);

    $display("[TB] framing error with held-low line");
    for (int h = 0; h < 2; h++) begin
      b_got = got_q.size(); b_fe = fe_count;
      applyStimulus(8'h3C, 1'b0, 1600);
      RxD = 1'b0;
      stepClk(holds[h]);
      checkOutput($sformatf("break%0d_busy_held", h), 32'(busy), 32'h1);
      checkOutput($sformatf("break%0d_valid", h), 32'(rx_valid), 32'h0);
      RxD = 1'b1;
      stepClk(30);
      checkOutput($sformatf("break%0d_busy_low", h), 32'(busy), 32'h0);
      checkOutput($sformatf("break%0d_fe", h), 32'(fe_count - b_fe), 32'd1);
      checkOutput($sformatf("break%0d_bytes", h), 32'(got_q.size() - b_got), 32'd0);
    end

    $display("[TB] overrun");
    rx_ready = 1'b0;
    b_fe = fe_count; b_ov = ov_count;
    applyStimulus(8'h11, 1'b1, 1600);
    applyStimulus(8'h22, 1'b1, 1600);
    RxD = 1'b1;
    stepClk(20);
    checkOutput("ovr_valid_held", 32'(rx_valid), 32'h1);
    checkOutput("ovr_data_held", 32'(rx_data), 32'h11);
    checkOutput("ovr_pulses", 32'(ov_count - b_ov), 32'd1);
    checkOutput("ovr_fe", 32'(fe_count - b_fe), 32'd0);
    rx_ready = 1'b1;
    stepClk(1);
    checkOutput("ovr_valid_cleared", 32'(rx_valid), 32'h0);
    checkOutput("ovr_accepted", 32'((got_q.size() > 0) ? {1'b0, got_q[got_q.size() - 1]} : 9'h100), 32'h11);
    stepClk(20);

    $display("[TB] skewed sweep and random frames");
    exp_q.delete();
    exp_fe = 0;
    b_got = got_q.size(); b_fe = fe_count; b_ov = ov_count;
    for (int v = 0; v < 256; v++) begin
      p = 1552 + int'($urandom_range(0, 96));
      exp_q.push_back(8'(v));
      applyStimulus(8'(v), 1'b1, p);
    end
    RxD = 1'b1;
    stepClk(32);
    for (int i = 0; i < 30; i++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 7) != 0);
      p    = 1552 + int'($urandom_range(0, 96));
      if (good) exp_q.push_back(d);
      else exp_fe++;
      applyStimulus(d, good, p);
      RxD = 1'b1;
      stepClk(good ? 8 * int'($urandom_range(0, 2)) : 16 + int'($urandom_range(0, 16)));
    end
    RxD = 1'b1;
    stepClk(48);
    checkOutput("rand_byte_count", 32'(got_q.size() - b_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput($sformatf("rand_byte%0d", i),
                  32'((b_got + i < got_q.size()) ? {1'b0, got_q[b_got + i]} : 9'h100),
                  32'({1'b0, exp_q[i]}));
    end
    checkOutput("rand_fe", 32'(fe_count - b_fe), 32'(exp_fe));
    checkOutput("rand_ov", 32'(ov_count - b_ov), 32'd0);
    checkOutput("flags_never_together", 32'(both_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Serial receive front end for the GPIO link. Takes the asynchronous 8N1 line (RxD), oversamples it 16x, validates start and stop bits, and presents each byte through a one-entry valid/ready holding register.
- Downstream logic (LED driver, command decoder) consumes bytes from that register.
- It is the receive counterpart of the switch-to-TxD path and shares its clock.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- DIV, CLK_FREQ/(BAUD*16) (derived localparam, integer truncation), clocks per oversample tick. It must be >= 1; elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- RxD  input  1  asynchronous serial line; idles high.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a byte was dropped because the holding register was full.
- busy  output  1  receiver is mid-frame (state != IDLE).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0; state=IDLE; synchronizer flops=1; tick counter=0.
- Synchronizer: 2-flop chain on RxD produces rx_s. All decisions use rx_s only.
- Tick generator: free-running counter 0..DIV-1; tick=1 in the cycle the count equals DIV-1, then the counter wraps to 0. With DIV=1, tick is high every cycle.
- Sample counter s (4 bit) advances only on tick. Bit value = majority of rx_s at s=7, 8 and 9.
- IDLE: on a tick with rx_s=0, go to START with s=0 and busy=1.
- START: at s=15, majority 0 → DATA with bit_idx=0; majority 1 → IDLE (glitch rejected, no flag raised).
- DATA: 16 ticks per bit. At s=15, shift the majority bit in LSB-first. After bit_idx=7, go to STOP.
- STOP: decide at s=9 (early exit allows resync on back-to-back frames).
  - Majority 1 → deliver the byte (see holding rules below), then go to IDLE.
  - Majority 0 → frame_err=1 for one cycle, byte discarded, go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. A held-low line never re-triggers START.
- Holding register rules, evaluated in the delivery cycle (the cycle after the s=9 stop tick):
  - rx_valid=0 → load rx_data, set rx_valid=1.
  - rx_valid=1 and rx_ready=1 → load the new byte; rx_valid stays 1.
  - rx_valid=1 and rx_ready=0 → old byte kept, new byte dropped, overrun=1 for one cycle.
  - In any other cycle, rx_valid=1 and rx_ready=1 clear rx_valid on the next edge.
  - rx_ready while rx_valid=0 is ignored.
- Reset mid-frame: abort immediately to IDLE. A partial byte is never delivered and no flag is raised.
- frame_err and overrun are never asserted together in the same cycle.

Decomposition:
- Package uart_pkg:
  - state enum IDLE/START/DATA/STOP/BREAK (3 bit).
  - OVERSAMPLE=16.
  - SAMPLE_A/B/C = 7/8/9.
  - DATA_BITS=8.
- Sub-module baud_tick_gen (parameter DIV; ports clk, reset, tick). It is reused by the transmit side.
- Everything else stays in uart_rx_sampler.

Test Plan (bench uses CLK_FREQ=16_000_000, BAUD=1_000_000, so DIV=1 and one bit = 16 clocks):
- Reset mid-frame: drive byte 0x55, assert reset during bit 3 for 1 cycle, then idle 20 bits → no rx_valid, no flags, busy=0 the cycle after reset.
- Single byte: send 0xA5 with rx_ready=1 → rx_valid pulses exactly one cycle with rx_data=0xA5; frame_err=0 and overrun=0.
- Glitch rejection: drive RxD low for 4 clocks then high → busy rises, returns 0 after the start-bit check, nothing delivered.
- Framing error: send 0x3C with the stop bit low, then hold the line low 40 clocks → one frame_err pulse, rx_valid stays 0, no new START until the line returns high.
- Overrun: rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data=0x11 held, one overrun pulse at the second delivery. Raising rx_ready then clears rx_valid next cycle.
- Sweep: send all 256 values back-to-back with rx_ready=1 and ±3% baud skew on the driver → all 256 bytes received in order, zero flags.
